// File: rtl/nav_arbiter_if.sv
// nav_arbiter_if
//   Bundles every handshake/data signal between the two requesters (M = manual
//   command path, S = autonomous maze solver), the navigate unit and the
//   arbiter. Clock and reset stay outside the interface.
//
//   master : environment side (requesters + navigate + fault clear)
//   slave  : arbiter side (nav_arbiter)
//
//   Signals:
//     m_/s_strt_hdng, m_/s_strt_mv   requester start pulses
//     m_/s_dsrd_hdng [11:0]          requester desired heading
//     m_/s_stp_lft, m_/s_stp_rght    requester stop-at-opening bits
//     m_done, s_done                 one-cycle completion pulse per requester
//     nav_strt_hdng, nav_strt_mv     start pulses to navigate
//     nav_dsrd_hdng [11:0]           heading to navigate
//     nav_stp_lft, nav_stp_rght      stop bits to navigate
//     mv_cmplt                       navigate completion pulse
//     clr_fault                      clears the watchdog fault
//     nav_fault                      sticky watchdog fault
//     busy                           operation in flight
interface nav_arbiter_if;
    logic        m_strt_hdng;
    logic        m_strt_mv;
    logic [11:0] m_dsrd_hdng;
    logic        m_stp_lft;
    logic        m_stp_rght;
    logic        m_done;

    logic        s_strt_hdng;
    logic        s_strt_mv;
    logic [11:0] s_dsrd_hdng;
    logic        s_stp_lft;
    logic        s_stp_rght;
    logic        s_done;

    logic        nav_strt_hdng;
    logic        nav_strt_mv;
    logic [11:0] nav_dsrd_hdng;
    logic        nav_stp_lft;
    logic        nav_stp_rght;
    logic        mv_cmplt;

    logic        clr_fault;
    logic        nav_fault;
    logic        busy;

    modport master (
        output m_strt_hdng, m_strt_mv, m_dsrd_hdng, m_stp_lft, m_stp_rght,
        output s_strt_hdng, s_strt_mv, s_dsrd_hdng, s_stp_lft, s_stp_rght,
        output mv_cmplt, clr_fault,
        input  m_done, s_done,
        input  nav_strt_hdng, nav_strt_mv, nav_dsrd_hdng, nav_stp_lft, nav_stp_rght,
        input  nav_fault, busy
    );

    modport slave (
        input  m_strt_hdng, m_strt_mv, m_dsrd_hdng, m_stp_lft, m_stp_rght,
        input  s_strt_hdng, s_strt_mv, s_dsrd_hdng, s_stp_lft, s_stp_rght,
        input  mv_cmplt, clr_fault,
        output m_done, s_done,
        output nav_strt_hdng, nav_strt_mv, nav_dsrd_hdng, nav_stp_lft, nav_stp_rght,
        output nav_fault, busy
    );
endinterface

// File: rtl/nav_arbiter.sv
// nav_arbiter
//   Shares the single navigate unit between requester M (manual commands) and
//   requester S (maze solver). Each requester's start pulse is captured into a
//   one-deep pending slot; one operation at a time is issued to navigate, its
//   mv_cmplt is routed back to the owning requester only, and a watchdog
//   raises a sticky fault if navigate never completes.
//
//   Ports:
//     clk     system clock
//     rst_n   asynchronous active-low reset
//     bus     nav_arbiter_if.slave (requester, navigate and fault signals)
//
//   Parameters:
//     TIMEOUT_CYC  cycles allowed in WAIT before fault (>= 2)
//     RST_HDNG     reset value of nav_dsrd_hdng
module nav_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter logic [11:0] RST_HDNG    = 12'h000
) (
    input logic          clk,
    input logic          rst_n,
    nav_arbiter_if.slave bus
);

    localparam int unsigned   TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    // Requester index: bit 0 = M, bit 1 = S.
    localparam logic REQ_M = 1'b0;
    localparam logic REQ_S = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FAULT
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            owner;
    logic            rr_last;

    // Per-requester pending slot.
    logic [1:0]       pend;
    logic [1:0]       op_hdng;
    logic [1:0][11:0] hdng;
    logic [1:0]       lft;
    logic [1:0]       rght;

    // Registered outputs.
    logic        m_done_reg;
    logic        s_done_reg;
    logic        strt_hdng_reg;
    logic        strt_mv_reg;
    logic [11:0] dsrd_hdng_reg;
    logic        stp_lft_reg;
    logic        stp_rght_reg;
    logic        fault_reg;
    logic        busy_reg;

    logic [1:0]  strt_h;
    logic [1:0]  strt_m;
    logic        in_flight;
    logic [1:0]  cap_ok;
    logic [1:0]  cap;
    logic        gnt_sel;

    always_comb begin
        strt_h    = {bus.s_strt_hdng, bus.m_strt_hdng};
        strt_m    = {bus.s_strt_mv, bus.m_strt_mv};
        in_flight = (state == ISSUE) || (state == WAIT);

        // A requester can be captured only if its slot is empty, it is not
        // the owner of the operation in flight, and no fault is pending.
        cap_ok[0] = (state != FAULT) && !pend[0] && !(in_flight && owner == REQ_M);
        cap_ok[1] = (state != FAULT) && !pend[1] && !(in_flight && owner == REQ_S);
        cap       = cap_ok & (strt_h | strt_m);

        // Tie goes to whoever was not granted last; otherwise the only one.
        gnt_sel = (pend == 2'b11) ? ~rr_last : pend[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            owner         <= REQ_M;
            rr_last       <= REQ_S;
            pend          <= '0;
            op_hdng       <= '0;
            hdng          <= '0;
            lft           <= '0;
            rght          <= '0;
            m_done_reg    <= 1'b0;
            s_done_reg    <= 1'b0;
            strt_hdng_reg <= 1'b0;
            strt_mv_reg   <= 1'b0;
            dsrd_hdng_reg <= RST_HDNG;
            stp_lft_reg   <= 1'b0;
            stp_rght_reg  <= 1'b0;
            fault_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            m_done_reg    <= 1'b0;
            s_done_reg    <= 1'b0;
            strt_hdng_reg <= 1'b0;
            strt_mv_reg   <= 1'b0;

            // Heading start takes precedence over a simultaneous move start.
            if (cap[0]) begin
                pend[0]    <= 1'b1;
                op_hdng[0] <= strt_h[0];
                hdng[0]    <= bus.m_dsrd_hdng;
                lft[0]     <= bus.m_stp_lft;
                rght[0]    <= bus.m_stp_rght;
            end
            if (cap[1]) begin
                pend[1]    <= 1'b1;
                op_hdng[1] <= strt_h[1];
                hdng[1]    <= bus.s_dsrd_hdng;
                lft[1]     <= bus.s_stp_lft;
                rght[1]    <= bus.s_stp_rght;
            end

            case (state)
                IDLE: begin
                    if (pend != 2'b00) begin
                        owner          <= gnt_sel;
                        rr_last        <= gnt_sel;
                        pend[gnt_sel]  <= 1'b0;
                        dsrd_hdng_reg  <= hdng[gnt_sel];
                        stp_lft_reg    <= lft[gnt_sel];
                        stp_rght_reg   <= rght[gnt_sel];
                        // Start pulse is registered here so it is high
                        // exactly during the ISSUE cycle.
                        strt_hdng_reg  <= op_hdng[gnt_sel];
                        strt_mv_reg    <= ~op_hdng[gnt_sel];
                        busy_reg       <= 1'b1;
                        state          <= ISSUE;
                    end
                end

                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    timer <= timer + 1'b1;
                    if (bus.mv_cmplt) begin
                        if (owner == REQ_M) begin
                            m_done_reg <= 1'b1;
                        end else begin
                            s_done_reg <= 1'b1;
                        end
                        busy_reg <= 1'b0;
                        state    <= IDLE;
                    end else if (timer == T_LAST) begin
                        // Overrides any capture made on this same edge.
                        pend      <= '0;
                        fault_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state     <= FAULT;
                    end
                end

                FAULT: begin
                    if (bus.clr_fault) begin
                        fault_reg <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_done        = m_done_reg;
    assign bus.s_done        = s_done_reg;
    assign bus.nav_strt_hdng = strt_hdng_reg;
    assign bus.nav_strt_mv   = strt_mv_reg;
    assign bus.nav_dsrd_hdng = dsrd_hdng_reg;
    assign bus.nav_stp_lft   = stp_lft_reg;
    assign bus.nav_stp_rght  = stp_rght_reg;
    assign bus.nav_fault     = fault_reg;
    assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_nav_arbiter.sv
// tb_nav_arbiter
//   Randomized rounds of requests from M and S against a transaction-level
//   model of the arbiter. The stimulus process predicts every output event
//   (issue, done, fault) with its cycle and pushes it into a queue; a monitor
//   pops and compares whenever the DUT shows an event.
module tb_nav_arbiter;

    localparam int unsigned TO = 16;
    localparam logic [11:0] RH = 12'hABC;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    nav_arbiter_if bus ();

    nav_arbiter #(.TIMEOUT_CYC(TO), .RST_HDNG(RH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_ISH, EV_ISM, EV_DM, EV_DS, EV_FLT} ev_k;
    typedef struct {
        ev_k         k;
        int unsigned c;
        logic [11:0] h;
        logic        l;
        logic        r;
    } ev_t;
    typedef struct {
        int unsigned op;   // 0 heading, 1 move, 2 both
        logic [11:0] h;
        logic        l;
        logic        r;
    } rq_t;

    ev_t exq[$];
    int  nvec = 0;
    int  nmis = 0;
    bit  rr_last = 1'b1;   // model: 0 = M granted last, 1 = S
    logic fault_q = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void chk_ev(ev_k k);
        ev_t e;
        bit  bad;
        nvec++;
        if (exq.size() == 0) begin
            nmis++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required none", k.name(), cyc);
            return;
        end
        e   = exq.pop_front();
        bad = (e.k != k) || (e.c != cyc);
        if (k == EV_ISH || k == EV_ISM)
            bad = bad || bus.nav_dsrd_hdng !== e.h || bus.nav_stp_lft !== e.l ||
                  bus.nav_stp_rght !== e.r || bus.busy !== 1'b1;
        else
            bad = bad || bus.busy !== 1'b0;
        if (bad) begin
            nmis++;
            $display("FAIL event: got %s @%0d hdng=%h l=%b r=%b busy=%b, required %s @%0d hdng=%h l=%b r=%b",
                     k.name(), cyc, bus.nav_dsrd_hdng, bus.nav_stp_lft, bus.nav_stp_rght, bus.busy,
                     e.k.name(), e.c, e.h, e.l, e.r);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.nav_strt_hdng) chk_ev(EV_ISH);
            if (bus.nav_strt_mv)   chk_ev(EV_ISM);
            if (bus.m_done)        chk_ev(EV_DM);
            if (bus.s_done)        chk_ev(EV_DS);
            if (bus.nav_fault && !fault_q) chk_ev(EV_FLT);
        end
        fault_q <= bus.nav_fault;
    end

    function automatic rq_t rand_req();
        rq_t q;
        q.op = $urandom_range(0, 2);
        q.h  = 12'($urandom);
        q.l  = 1'($urandom);
        q.r  = 1'($urandom);
        return q;
    endfunction

    function automatic void push(ev_k k, int unsigned c, rq_t q);
        ev_t e;
        e.k = k; e.c = c; e.h = q.h; e.l = q.l; e.r = q.r;
        exq.push_back(e);
    endfunction

    task automatic go_to(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive(input bit w, input rq_t q);
        if (!w) begin
            bus.m_strt_hdng = (q.op != 1);
            bus.m_strt_mv   = (q.op != 0);
            bus.m_dsrd_hdng = q.h;
            bus.m_stp_lft   = q.l;
            bus.m_stp_rght  = q.r;
        end else begin
            bus.s_strt_hdng = (q.op != 1);
            bus.s_strt_mv   = (q.op != 0);
            bus.s_dsrd_hdng = q.h;
            bus.s_stp_lft   = q.l;
            bus.s_stp_rght  = q.r;
        end
    endtask

    // Pulses drop; data lines get junk that must not reach navigate.
    task automatic clear_pulses();
        bus.m_strt_hdng = 1'b0; bus.m_strt_mv = 1'b0;
        bus.s_strt_hdng = 1'b0; bus.s_strt_mv = 1'b0;
        bus.m_dsrd_hdng = 12'($urandom); bus.s_dsrd_hdng = 12'($urandom);
        bus.m_stp_lft = 1'($urandom); bus.m_stp_rght = 1'($urandom);
        bus.s_stp_lft = 1'($urandom); bus.s_stp_rght = 1'($urandom);
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_strt_hdng"}, 32'(bus.nav_strt_hdng), 0);
        chk({tag, "_strt_mv"},   32'(bus.nav_strt_mv), 0);
        chk({tag, "_dsrd_hdng"}, 32'(bus.nav_dsrd_hdng), 32'(RH));
        chk({tag, "_stp_lft"},   32'(bus.nav_stp_lft), 0);
        chk({tag, "_stp_rght"},  32'(bus.nav_stp_rght), 0);
        chk({tag, "_m_done"},    32'(bus.m_done), 0);
        chk({tag, "_s_done"},    32'(bus.s_done), 0);
        chk({tag, "_fault"},     32'(bus.nav_fault), 0);
        chk({tag, "_busy"},      32'(bus.busy), 0);
    endtask

    // mode: 0 normal, 1 watchdog timeout, 2 reset mid-WAIT
    task automatic run_round(input int unsigned who, input int unsigned mode,
                             input int unsigned dfix, input bit directed);
        rq_t         r[2];
        rq_t         nr;
        bit          pend[2];
        bit          g;
        int unsigned c0, t, d, c1;
        c0 = cyc;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (who[w]) begin
                r[w] = rand_req();
                if (directed) begin r[w].op = 0; r[w].h = 12'h400; end
                pend[w] = 1'b1;
                drive(w[0], r[w]);
            end
        end
        go_to(c0 + 1);
        clear_pulses();
        // Repeat pulses from requesters that are already pending.
        for (int w = 0; w < 2; w++)
            if (pend[w] && $urandom_range(0, 1) == 1) drive(w[0], rand_req());
        t = c0 + 2;
        while (pend[0] || pend[1]) begin
            g = (pend[0] && pend[1]) ? !rr_last : !pend[0];
            rr_last = g;
            pend[g] = 1'b0;
            push((r[g].op == 1) ? EV_ISM : EV_ISH, t, r[g]);
            if (mode == 1) begin
                push(EV_FLT, t + TO + 1, r[g]);
                pend[0] = 1'b0; pend[1] = 1'b0;
                go_to(t);
                clear_pulses();
                go_to(t + TO + 2);
                chk("fault_held", 32'(bus.nav_fault), 1);
                drive(1'b1, rand_req());
                drive(1'b0, rand_req());
                bus.mv_cmplt = 1'b1;
                go_to(t + TO + 3);
                clear_pulses();
                bus.mv_cmplt = 1'b0;
                go_to(t + TO + 4);
                bus.clr_fault = 1'b1;
                go_to(t + TO + 5);
                bus.clr_fault = 1'b0;
                chk("fault_cleared", 32'(bus.nav_fault), 0);
                chk("busy_after_clear", 32'(bus.busy), 0);
                return;
            end
            if (mode == 2) begin
                go_to(t);
                clear_pulses();
                go_to(t + 3);
                #2 rst_n = 1'b0;
                #1 reset_checks("midwait_rst");
                @(negedge clk);
                rst_n = 1'b1;
                pend[0] = 1'b0; pend[1] = 1'b0;
                rr_last = 1'b1;
                c1 = cyc;
                go_to(c1 + 1);
                bus.mv_cmplt = 1'b1;
                go_to(c1 + 2);
                bus.mv_cmplt = 1'b0;
                return;
            end
            d = (dfix != 0) ? dfix : $urandom_range(1, TO);
            go_to(t);
            clear_pulses();
            bus.mv_cmplt = ($urandom_range(0, 3) == 0);   // in ISSUE: ignored
            go_to(t + 1);
            bus.mv_cmplt = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                nr = rand_req();
                drive(!g, nr);
                if (!pend[!g]) begin r[!g] = nr; pend[!g] = 1'b1; end
            end
            if ($urandom_range(0, 1) == 1) drive(g, rand_req());   // owner: ignored
            if (d == 1) bus.mv_cmplt = 1'b1;
            if (d > 1) begin
                go_to(t + 2);
                clear_pulses();
                go_to(t + d);
                bus.mv_cmplt = 1'b1;
            end
            push(g ? EV_DS : EV_DM, t + d + 1, r[g]);
            go_to(t + d + 1);
            clear_pulses();
            bus.mv_cmplt = ($urandom_range(0, 3) == 0);   // in IDLE: ignored
            t = t + d + 2;
        end
        go_to(t);
        clear_pulses();
        bus.mv_cmplt = 1'b0;
    endtask

    initial begin
        bus.mv_cmplt  = 1'b0;
        bus.clr_fault = 1'b0;
        clear_pulses();
        #1 rst_n = 1'b0;
        #2 reset_checks("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_round(1, 0, 8, 1'b1);
        run_round(3, 0, 0, 1'b0);
        run_round(3, 0, TO, 1'b0);
        run_round(3, 1, 0, 1'b0);
        run_round(2, 0, 0, 1'b0);
        for (int i = 0; i < 45; i++) begin
            int unsigned mode;
            mode = (i % 11 == 5) ? 1 : (i == 20 || i == 37) ? 2 : 0;
            run_round($urandom_range(1, 3), mode, (i % 6 == 0) ? TO : 0, 1'b0);
            go_to(cyc + $urandom_range(0, 3));
        end

        go_to(cyc + 5);
        chk("queue_drained", 32'(exq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/nav_arbiter.md
Name: nav_arbiter

Overview:
- Shares the single navigate unit (heading controller + move engine) between two requesters: the manual command path (requester M) and the autonomous maze solver (requester S).
- Captures each requester's heading/move start pulses and issues one operation at a time to navigate.
- Routes navigate's mv_cmplt back to the owning requester only.
- Runs a watchdog on every outstanding operation and latches a sticky fault on timeout.

Parameters:
- TIMEOUT_CYC, 50_000_000, cycles allowed in WAIT before fault (1 s at 50 MHz); must be >= 2.
- RST_HDNG, 12'h000, reset value of nav_dsrd_hdng.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- m_strt_hdng  in  1  requester M heading-start pulse
- m_strt_mv  in  1  requester M move-start pulse
- m_dsrd_hdng  in  12  requester M desired heading
- m_stp_lft  in  1  requester M stop-at-left-opening
- m_stp_rght  in  1  requester M stop-at-right-opening
- m_done  out  1  one-cycle completion pulse to M
- s_strt_hdng, s_strt_mv, s_dsrd_hdng, s_stp_lft, s_stp_rght  in  1/1/12/1/1  same as M, for requester S
- s_done  out  1  one-cycle completion pulse to S
- nav_strt_hdng  out  1  heading-start pulse to navigate
- nav_strt_mv  out  1  move-start pulse to navigate
- nav_dsrd_hdng  out  12  heading to navigate
- nav_stp_lft  out  1  stop-left to navigate
- nav_stp_rght  out  1  stop-right to navigate
- mv_cmplt  in  1  navigate completion pulse
- clr_fault  in  1  clears fault, returns arbiter to IDLE
- nav_fault  out  1  sticky watchdog fault
- busy  out  1  high in ISSUE or WAIT

Behaviour:
- Reset: state IDLE; pending flags, done pulses, nav_strt_* and nav_fault = 0; timer = 0; nav_stp_* = 0; nav_dsrd_hdng = RST_HDNG; rr_last = S, so M wins the first tie.
- Capture, per requester:
  - A start pulse sets pending, latches op type (HDNG/MV), heading and stp bits on the same edge.
  - If strt_hdng and strt_mv arrive together, HDNG is latched and MV is dropped.
  - A pulse while that requester is pending, or is owner in ISSUE/WAIT, is ignored; the latched values stay unchanged.
- States: IDLE, ISSUE, WAIT, FAULT.
- IDLE:
  - One pending -> grant it.
  - Both pending -> grant the requester not equal to rr_last, then update rr_last.
  - On grant: copy the owner's latched heading and stp bits to the nav_* registers, clear the owner's pending, go to ISSUE.
- ISSUE (1 cycle):
  - Drive nav_strt_hdng or nav_strt_mv (per op type) high for exactly this cycle.
  - Clear the timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - mv_cmplt=1 -> registered owner_done pulse, high exactly the next cycle; go to IDLE.
  - Else if timer == TIMEOUT_CYC-1 -> go to FAULT, set nav_fault, clear both pending flags, no done pulse.
  - mv_cmplt wins over a same-cycle timeout.
- FAULT:
  - No grants; new requests are ignored (not captured).
  - clr_fault -> nav_fault=0, go to IDLE.
- mv_cmplt outside WAIT is ignored.
- nav_dsrd_hdng and nav_stp_* hold their values from grant until the next grant.
- Latency: request pulse in cycle N (IDLE, nothing pending) -> nav_strt_* high in cycle N+2 -> mv_cmplt in cycle K -> owner done high in cycle K+1.
- Back-to-back: done in cycle K+1 coincides with IDLE, so the next pending op's nav_strt_* is high in K+2.
- Heading arithmetic: none; 12-bit values pass through unmodified, wrap semantics belong to the requesters.
- Timer width: $clog2(TIMEOUT_CYC+1); saturation is not needed because FAULT is entered first.
- Reset mid-operation: everything returns to reset values immediately (async); an outstanding navigate op is abandoned.

Test Plan:
- Single M heading: m_strt_hdng with m_dsrd_hdng=12'h400 in cycle 0 -> nav_strt_hdng high in cycle 2 only, nav_dsrd_hdng=12'h400; mv_cmplt in cycle 10 -> m_done high in cycle 11 only, s_done stays 0.
- Tie and round-robin:
  - M and S pulse strt_mv in the same cycle -> M issued first.
  - After M completes, S issued, with nav_stp_* equal to S's latched bits.
  - Repeat tie -> M first again, since rr_last is then S.
- Duplicate and dual start: M pulses strt_mv twice while pending -> exactly one nav_strt_mv. M pulses strt_hdng and strt_mv together -> nav_strt_hdng only.
- Watchdog (TIMEOUT_CYC=16): issue op, withhold mv_cmplt -> nav_fault rises after 16 WAIT cycles, no done pulse, S request ignored while faulted. clr_fault -> IDLE, new request served normally.
- Timeout tie: mv_cmplt asserted on the cycle timer==15 -> done pulse, nav_fault stays 0.
- Reset mid-WAIT: deassert rst_n -> all outputs at reset values in the same cycle; a later mv_cmplt produces no done pulse.
